// File: rtl/router_fsm.sv
// ============================================================================
// router_fsm : packet-flow controller for the 3-port router (header decode,
//              payload/parity load, full-stall handling, per-port timeout).
// Rev 1.0
// ============================================================================
`default_nettype none

module router_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_addr;
  logic       w_hdr_ok;
  logic       w_empty_hdr;
  logic       w_empty_sel;
  logic       w_soft_sel;

  assign w_hdr_ok = pkt_valid && (data_in != 2'd3);

  // Port selects: the header byte picks the FIFO for the first decision,
  // the latched address governs everything after that.
  always_comb begin
    w_empty_hdr = 1'b0;
    w_empty_sel = 1'b0;
    w_soft_sel  = 1'b0;
    case (data_in)
      2'd0:    w_empty_hdr = fifo_empty_0;
      2'd1:    w_empty_hdr = fifo_empty_1;
      2'd2:    w_empty_hdr = fifo_empty_2;
      default: w_empty_hdr = 1'b0;
    endcase
    case (r_addr)
      2'd0:    begin w_empty_sel = fifo_empty_0; w_soft_sel = soft_reset_0; end
      2'd1:    begin w_empty_sel = fifo_empty_1; w_soft_sel = soft_reset_1; end
      2'd2:    begin w_empty_sel = fifo_empty_2; w_soft_sel = soft_reset_2; end
      default: begin w_empty_sel = 1'b0;         w_soft_sel = 1'b0;         end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DECODE_ADDRESS && w_hdr_ok)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DECODE_ADDRESS:
        if (w_hdr_ok)
          w_next_state = w_empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:
        w_next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       w_next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full)      w_next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        w_next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) w_next_state = LOAD_PARITY;
        else                    w_next_state = LOAD_DATA;
      LOAD_PARITY:
        w_next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:
        if (w_empty_sel)     w_next_state = LOAD_FIRST_DATA;
      default:
        w_next_state = DECODE_ADDRESS;
    endcase
    // Timeout on the active port aborts the packet from any busy state.
    if (r_state != DECODE_ADDRESS && w_soft_sel)
      w_next_state = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    full_state    = (r_state == FIFO_FULL_STATE);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                    (r_state == LOAD_AFTER_FULL);
    busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
  end

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// ============================================================================
// tb_router_fsm : scoreboard bench for router_fsm.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_router_fsm;

  localparam int S_DA  = 0;
  localparam int S_LFD = 1;
  localparam int S_LD  = 2;
  localparam int S_FFS = 3;
  localparam int S_LAF = 4;
  localparam int S_LP  = 5;
  localparam int S_CPE = 6;
  localparam int S_WTE = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  router_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy)
  );

  wire [7:0] w_outs = {detect_add, lfd_state, ld_state, laf_state,
                       full_state, rst_int_reg, write_enb_reg, busy};

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  function automatic logic [7:0] exp_vec(input int st);
    case (st)
      S_DA:    return 8'b1000_0000;
      S_LFD:   return 8'b0100_0001;
      S_LD:    return 8'b0010_0010;
      S_LAF:   return 8'b0001_0011;
      S_FFS:   return 8'b0000_1001;
      S_CPE:   return 8'b0000_0101;
      S_LP:    return 8'b0000_0011;
      default: return 8'b0000_0001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic defaults();
    pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  // Inputs are already set by the caller; push what the state after the
  // coming edge must look like, then compare once that edge has passed.
  task automatic cyc(input string tag, input int exp_st);
    logic [7:0] e;
    sb_q.push_back(exp_vec(exp_st));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty got %b want entry", tag, w_outs);
    end else begin
      e = sb_q.pop_front();
      chk(tag, w_outs, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    defaults();
    reset = 1'b1;
    #3;
    chk("reset_outs", w_outs, exp_vec(S_DA));
    @(posedge clk); #1;
    chk("reset_held", w_outs, exp_vec(S_DA));
    reset = 1'b0;

    // Idle with no valid header stays put.
    data_in = 2'd1; cyc("idle", S_DA);

    // Three-payload packet to port 1.
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc("p1_lfd", S_LFD);
    data_in = 2'd3;
    cyc("p1_ld0", S_LD);
    cyc("p1_ld1", S_LD);
    cyc("p1_ld2", S_LD);
    pkt_valid = 1'b0;
    cyc("p1_lp", S_LP);
    cyc("p1_cpe", S_CPE);
    cyc("p1_da", S_DA);

    // Port 2 busy for four cycles, then drains.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    cyc("w2_wte0", S_WTE);
    data_in = 2'd0;
    for (int i = 1; i < 4; i++) cyc($sformatf("w2_wte%0d", i), S_WTE);
    fifo_empty_2 = 1'b1;
    cyc("w2_lfd", S_LFD);
    cyc("w2_ld", S_LD);
    pkt_valid = 1'b0;
    cyc("w2_lp", S_LP);
    cyc("w2_cpe", S_CPE);
    cyc("w2_da", S_DA);

    // Invalid address 3 is ignored.
    pkt_valid = 1'b1; data_in = 2'd3;
    cyc("a3_da0", S_DA);
    cyc("a3_da1", S_DA);

    // Full stall of three cycles, exit via low_pkt_valid.
    data_in = 2'd0;
    cyc("f_lfd", S_LFD);
    cyc("f_ld", S_LD);
    fifo_full = 1'b1;
    cyc("f_ffs0", S_FFS);
    cyc("f_ffs1", S_FFS);
    cyc("f_ffs2", S_FFS);
    fifo_full = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
    cyc("f_laf", S_LAF);
    cyc("f_lp", S_LP);
    low_pkt_valid = 1'b0;
    cyc("f_cpe", S_CPE);
    cyc("f_da", S_DA);

    // LAF back to LD, CPE into full, LAF exit on parity_done.
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc("g_lfd", S_LFD);
    cyc("g_ld", S_LD);
    fifo_full = 1'b1;
    cyc("g_ffs", S_FFS);
    fifo_full = 1'b0;
    cyc("g_laf", S_LAF);
    cyc("g_ld2", S_LD);
    pkt_valid = 1'b0;
    cyc("g_lp", S_LP);
    fifo_full = 1'b1;
    cyc("g_cpe", S_CPE);
    cyc("g_ffs2", S_FFS);
    fifo_full = 1'b0;
    cyc("g_laf2", S_LAF);
    parity_done = 1'b1;
    cyc("g_da", S_DA);
    parity_done = 1'b0;

    // Soft reset: other port ignored, own port aborts.
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
    cyc("s_wte", S_WTE);
    pkt_valid = 1'b0; soft_reset_1 = 1'b1;
    cyc("s_other", S_WTE);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    cyc("s_own", S_DA);
    // Soft reset has no effect while decoding.
    fifo_empty_0 = 1'b1; pkt_valid = 1'b1;
    cyc("s_in_da", S_LFD);
    soft_reset_0 = 1'b0;
    cyc("s_ld", S_LD);
    // Soft reset beats the fifo_full transition out of LD.
    fifo_full = 1'b1; soft_reset_0 = 1'b1;
    cyc("s_prio", S_DA);
    defaults();

    // Asynchronous reset mid-LOAD_DATA.
    pkt_valid = 1'b1; data_in = 2'd2;
    cyc("r_lfd", S_LFD);
    cyc("r_ld", S_LD);
    #2;
    reset = 1'b1;
    #1;
    chk("r_async", w_outs, exp_vec(S_DA));
    @(posedge clk); #1;
    reset = 1'b0;
    data_in = 2'd1;
    cyc("r_after", S_LFD);
    defaults();
    cyc("r_ld2", S_LD);
    cyc("r_lp", S_LP);
    cyc("r_cpe", S_CPE);
    cyc("r_da", S_DA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
